// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digit cells.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage : bcd_pkg

// File: rtl/bcd1_counter.sv
// Single BCD digit up-counter (0..9) with count enable and synchronous
// active-low clear. Codes 10..15 are unreachable after reset; if they ever
// appear, an enabled edge folds them back to 0 and a disabled edge holds them.
module bcd1_counter
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  output logic [BCD_W-1:0] out
);

  bcd_digit_t out_q;
  bcd_digit_t out_d;

  // Next digit: hold when disabled, wrap at 9 (and on any illegal code), else +1.
  always_comb begin
    out_d = out_q;
    if (x) begin
      if (out_q >= BCD_MAX) begin
        out_d = '0;
      end else begin
        out_d = out_q + 4'd1;
      end
    end
  end

  // Digit register; clear has priority over the enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : bcd1_counter

// File: tb/tb_bcd1_counter.sv
// Directed bench for bcd1_counter: reset, counting with wrap, hold,
// reset priority, a slowly toggling enable and an illegal register code.
module tb_bcd1_counter;

  logic       clk;
  logic       reset;
  logic       x;
  logic [3:0] out;

  int n_checks;
  int n_errors;

  bcd1_counter dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_chk(input string tag, input logic [3:0] exp);
    @(negedge clk);
    chk(tag, out, exp);
  endtask

  initial begin
    logic [3:0] model;
    logic       xs;
    n_checks = 0;
    n_errors = 0;

    // Reset held low for two edges, x at both values.
    reset = 1'b0;
    x     = 1'b1;
    step_chk("reset_e1", 4'd0);
    x = 1'b0;
    step_chk("reset_e2", 4'd0);

    // Release with x high: 1..9,0,1,2 over 12 edges.
    reset = 1'b1;
    x     = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step_chk("count_wrap", 4'((i + 1) % 10));
    end
    step_chk("count_3", 4'd3);
    step_chk("count_4", 4'd4);

    // Hold at 4 for five edges, then one enabled edge.
    x = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_chk("hold_4", 4'd4);
    end
    x = 1'b1;
    step_chk("resume_5", 4'd5);
    step_chk("count_6", 4'd6);
    step_chk("count_7", 4'd7);
    step_chk("count_8", 4'd8);

    // Reset at 8 with x high must give 0, not 9.
    reset = 1'b0;
    step_chk("reset_prio", 4'd0);
    reset = 1'b1;

    // Slow enable: x toggles every 15 ns, transitions 2 ns / 7 ns after
    // a negedge-aligned start, so never on a rising edge (edges at 5 mod 10).
    model = 4'd0;
    x     = 1'b0;
    fork
      begin
        #2;
        repeat (14) begin
          x = ~x;
          #15;
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk);
          xs = x;
          if (xs) model = (model == 4'd9) ? 4'd0 : model + 4'd1;
          @(negedge clk);
          chk("slow_en", out, model);
        end
      end
    join
    @(negedge clk);
    x = 1'b0;
    @(negedge clk);
    chk("slow_en_final", out, model);

    // Illegal code 12: hold with x low, fold to 0 with x high.
    force dut.out_q = 4'd12;
    #1;
    release dut.out_q;
    chk("illegal_load", out, 4'd12);
    step_chk("illegal_hold", 4'd12);
    x = 1'b1;
    step_chk("illegal_fold", 4'd0);
    step_chk("after_fold", 4'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_bcd1_counter
